// File: rtl/wave_pwm_driver.sv
// Purpose: turns triangle-wave samples into fixed 2^WIDTH-tick PWM frames and monitors the wave shape.
// Latency: pwm_out lags the frame counter by 1 clk; the monitor pulses land on the edge sampling the new wave.
// Backpressure: none; the wave is consumed every clk, and en gates only the PWM path.
`timescale 1ns/1ps
module wave_pwm_driver #(
   parameter int WIDTH    = 5,
   parameter int PRESCALE = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] wave,
   output logic             pwm_out,
   output logic [WIDTH-1:0] duty,
   output logic             frame_start,
   output logic             peak_pulse,
   output logic             trough_pulse,
   output logic             step_err,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int               PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] CNT_LAST = '1;
   localparam logic [WIDTH:0]   ONE_LSB  = (WIDTH+1)'(1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
   typedef enum logic {DOWN = 1'b0, UP  = 1'b1} dir_t;

   state_t           state, state_nxt;
   logic [PSC_W-1:0] psc, psc_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] duty_nxt;
   logic             frame_start_nxt;
   logic             tick;

   logic [WIDTH-1:0] wave_d;
   logic             hist_v;
   dir_t             dir;
   logic [WIDTH:0]   step_mag;

   assign tick = (psc == PSC_LAST);

   // PWM state register; the output compares the pre-edge counter against the latched duty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         psc         <= '0;
         cnt         <= '0;
         duty        <= '0;
         frame_start <= 1'b0;
         pwm_out     <= 1'b0;
      end else begin
         state       <= state_nxt;
         psc         <= psc_nxt;
         cnt         <= cnt_nxt;
         duty        <= duty_nxt;
         frame_start <= frame_start_nxt;
         pwm_out     <= (state == RUN) && (cnt < duty);
      end
   end

   // Next-state logic: duty is only re-latched on frame entry or at the end of a full frame
   always_comb begin
      state_nxt       = state;
      psc_nxt         = psc;
      cnt_nxt         = cnt;
      duty_nxt        = duty;
      frame_start_nxt = 1'b0;
      case (state)
         IDLE: begin
            psc_nxt = '0;
            cnt_nxt = '0;
            if (en) begin
               state_nxt       = RUN;
               duty_nxt        = wave;
               frame_start_nxt = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               state_nxt = IDLE;
               psc_nxt   = '0;
               cnt_nxt   = '0;
            end else if (tick) begin
               psc_nxt = '0;
               cnt_nxt = cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  duty_nxt        = wave;
                  frame_start_nxt = 1'b1;
               end
            end else begin
               psc_nxt = psc + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Absolute step between consecutive samples, widened so 31->0 does not wrap
   always_comb begin
      step_mag = '0;
      if (wave > wave_d) step_mag = {1'b0, wave} - {1'b0, wave_d};
      else               step_mag = {1'b0, wave_d} - {1'b0, wave};
   end

   // Waveform monitor: reversal pulses, illegal-step flag and saturating trough counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_d       <= '0;
         hist_v       <= 1'b0;
         dir          <= UP;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         step_err     <= 1'b0;
         cycle_cnt    <= '0;
      end else begin
         wave_d       <= wave;
         hist_v       <= 1'b1;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         step_err     <= hist_v && (step_mag > ONE_LSB);
         if (hist_v) begin
            if ((wave > wave_d) && (dir == DOWN)) begin
               trough_pulse <= 1'b1;
               dir          <= UP;
               if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
            end else if ((wave < wave_d) && (dir == UP)) begin
               peak_pulse <= 1'b1;
               dir        <= DOWN;
            end
         end
      end
   end

endmodule

// File: tb/tb_wave_pwm_driver.sv
// Bench for wave_pwm_driver: PWM frames at PRESCALE=1 and 4, enable drop/re-raise, async reset, monitor.
// Expected values come from constant tables pushed through scoreboard queues.
// Inputs driven 1 ns after the rising edge; outputs sampled at the same point.
`timescale 1ns/1ps
module tb_wave_pwm_driver;
   localparam int WIDTH = 5;
   localparam int CNT_W = 16;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             en    = 1'b0;
   logic             en4   = 1'b0;
   logic [WIDTH-1:0] wave  = '0;
   logic [WIDTH-1:0] wave4 = '0;

   logic             pwm_out, frame_start, peak_pulse, trough_pulse, step_err;
   logic [WIDTH-1:0] duty;
   logic [CNT_W-1:0] cycle_cnt;
   logic             pwm_out4, frame_start4, peak_pulse4, trough_pulse4, step_err4;
   logic [WIDTH-1:0] duty4;
   logic [CNT_W-1:0] cycle_cnt4;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [WIDTH-1:0] w; int exp_high; } frame_vec_t;
   typedef struct { logic [WIDTH-1:0] duty; int high; } frame_exp_t;
   typedef struct { logic [WIDTH-1:0] w; logic peak; logic trough; logic err; int cnt; } mon_vec_t;

   frame_exp_t frame_q[$];
   mon_vec_t   mon_q[$];

   wave_pwm_driver #(.WIDTH(WIDTH), .PRESCALE(1), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wave(wave),
      .pwm_out(pwm_out), .duty(duty), .frame_start(frame_start),
      .peak_pulse(peak_pulse), .trough_pulse(trough_pulse),
      .step_err(step_err), .cycle_cnt(cycle_cnt)
   );

   wave_pwm_driver #(.WIDTH(WIDTH), .PRESCALE(4), .CNT_W(CNT_W)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .wave(wave4),
      .pwm_out(pwm_out4), .duty(duty4), .frame_start(frame_start4),
      .peak_pulse(peak_pulse4), .trough_pulse(trough_pulse4),
      .step_err(step_err4), .cycle_cnt(cycle_cnt4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_vec_t ftbl[6];
      mon_vec_t   mtbl[17];
      frame_exp_t fe;
      mon_vec_t   me;
      logic [WIDTH-1:0] duty31;
      int highs, pat_err, fs_cnt, n;
      bit seen;

      ftbl[0] = '{w:5'd8,  exp_high:8};
      ftbl[1] = '{w:5'd0,  exp_high:0};
      ftbl[2] = '{w:5'd31, exp_high:31};
      ftbl[3] = '{w:5'd8,  exp_high:8};   // wave switches to 20 at cnt=10 inside this frame
      ftbl[4] = '{w:5'd20, exp_high:20};
      ftbl[5] = '{w:5'd8,  exp_high:8};

      mtbl[0]  = '{w:5'd0,  peak:0, trough:0, err:0, cnt:0};
      mtbl[1]  = '{w:5'd1,  peak:0, trough:0, err:0, cnt:0};
      mtbl[2]  = '{w:5'd2,  peak:0, trough:0, err:0, cnt:0};
      mtbl[3]  = '{w:5'd3,  peak:0, trough:0, err:0, cnt:0};
      mtbl[4]  = '{w:5'd2,  peak:1, trough:0, err:0, cnt:0};
      mtbl[5]  = '{w:5'd1,  peak:0, trough:0, err:0, cnt:0};
      mtbl[6]  = '{w:5'd0,  peak:0, trough:0, err:0, cnt:0};
      mtbl[7]  = '{w:5'd1,  peak:0, trough:1, err:0, cnt:1};
      mtbl[8]  = '{w:5'd30, peak:0, trough:0, err:1, cnt:1};
      mtbl[9]  = '{w:5'd31, peak:0, trough:0, err:0, cnt:1};
      mtbl[10] = '{w:5'd0,  peak:1, trough:0, err:1, cnt:1};
      mtbl[11] = '{w:5'd0,  peak:0, trough:0, err:0, cnt:1};
      mtbl[12] = '{w:5'd1,  peak:0, trough:1, err:0, cnt:2};
      mtbl[13] = '{w:5'd1,  peak:0, trough:0, err:0, cnt:2};
      mtbl[14] = '{w:5'd0,  peak:1, trough:0, err:0, cnt:2};
      mtbl[15] = '{w:5'd5,  peak:0, trough:1, err:1, cnt:3};
      mtbl[16] = '{w:5'd5,  peak:0, trough:0, err:0, cnt:3};

      // reset state
      #1 rst_n = 1'b0;
      #2;
      check("reset_outputs", {pwm_out, duty, frame_start, peak_pulse, trough_pulse, step_err, cycle_cnt}, '0);
      check("reset_outputs_p4", {pwm_out4, duty4, frame_start4, peak_pulse4, trough_pulse4, step_err4, cycle_cnt4}, '0);
      repeat (2) step();
      check("reset_held", {pwm_out, duty, frame_start, cycle_cnt}, '0);
      rst_n = 1'b1;

      // PWM frames at PRESCALE=1
      wave = ftbl[0].w;
      en   = 1'b1;
      frame_q.push_back('{duty:ftbl[0].w, high:ftbl[0].exp_high});
      step();
      check("first_frame_start", frame_start, 1);
      check("first_duty", duty, ftbl[0].w);

      for (int i = 0; i < 6; i++) begin
         highs = 0; pat_err = 0; fs_cnt = 0; duty31 = '0;
         for (int s = 1; s <= 32; s++) begin
            step();
            if (pwm_out) highs++;
            if (pwm_out !== (s <= frame_q[0].high)) pat_err++;
            if (frame_start) fs_cnt++;
            if (s == 31) duty31 = duty;
            if (s == 10 && i < 5) begin
               wave = ftbl[i+1].w;
               frame_q.push_back('{duty:ftbl[i+1].w, high:ftbl[i+1].exp_high});
            end
         end
         fe = frame_q.pop_front();
         check($sformatf("frame%0d_high_count", i), highs, fe.high);
         check($sformatf("frame%0d_pwm_pattern_errs", i), pat_err, 0);
         check($sformatf("frame%0d_duty", i), duty31, fe.duty);
         check($sformatf("frame%0d_frame_start_count", i), fs_cnt, 1);
         check($sformatf("frame%0d_boundary_pulse", i), frame_start, 1);
      end
      check("duty_after_last_frame", duty, 8);

      // enable drop at cnt=5 with duty=8
      repeat (5) step();
      check("pwm_high_before_drop", pwm_out, 1);
      en = 1'b0;
      step();
      step();
      check("pwm_low_after_en_drop", pwm_out, 0);
      check("no_frame_start_on_drop", frame_start, 0);
      step();
      check("pwm_stays_low_idle", pwm_out, 0);
      check("duty_held_idle", duty, 8);

      // re-raise with a fresh duty
      wave = 5'd13;
      en   = 1'b1;
      step();
      check("reraise_frame_start", frame_start, 1);
      check("reraise_duty", duty, 13);
      repeat (3) step();
      check("pwm_high_before_reset", pwm_out, 1);
      check("cycle_cnt_before_reset", cycle_cnt, 3);

      // async reset mid-frame, away from the clock edge
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_pwm", pwm_out, 0);
      check("async_reset_duty", duty, 0);
      check("async_reset_cycle_cnt", cycle_cnt, 0);
      en   = 1'b0;
      wave = '0;
      repeat (2) step();
      rst_n = 1'b1;

      // monitor sequence from reset
      for (int k = 0; k < 17; k++) begin
         wave = mtbl[k].w;
         mon_q.push_back(mtbl[k]);
         step();
         me = mon_q.pop_front();
         check($sformatf("mon%0d_peak", k), peak_pulse, me.peak);
         check($sformatf("mon%0d_trough", k), trough_pulse, me.trough);
         check($sformatf("mon%0d_step_err", k), step_err, me.err);
         check($sformatf("mon%0d_cycle_cnt", k), cycle_cnt, me.cnt);
      end
      check("pwm_idle_during_monitor", pwm_out, 0);

      // PRESCALE=4: one frame is 128 clks, duty 8 gives 32 high clks
      wave4 = 5'd8;
      en4   = 1'b1;
      step();
      check("p4_frame_start", frame_start4, 1);
      check("p4_duty", duty4, 8);
      n = 0; highs = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         step();
         n++;
         if (pwm_out4) highs++;
         if (frame_start4) seen = 1'b1;
      end
      check("p4_frame_seen", seen, 1);
      check("p4_frame_len", n, 128);
      check("p4_high_count", highs, 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wave_pwm_driver.md
Name: wave_pwm_driver

Overview:
- Downstream consumer of the 5-bit triangle-wave generator.
- Converts each wave sample into a fixed-frame PWM output for an off-chip RC-filter DAC.
- Runs a waveform monitor alongside the PWM path:
  - detects peaks and troughs (direction reversals);
  - flags illegal steps larger than 1 LSB;
  - counts completed triangle cycles.

Parameters:
- WIDTH, 5: wave/duty width; PWM frame length is 2^WIDTH counter ticks.
- PRESCALE, 1: clk cycles per PWM counter tick (>=1).
- CNT_W, 16: width of the triangle-cycle counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  PWM enable, level-sensitive
- wave  in  WIDTH  sample from the triangle generator, valid every clk
- pwm_out  out  1  registered PWM output
- duty  out  WIDTH  duty value latched for the current frame
- frame_start  out  1  one-cycle pulse when a new duty is latched
- peak_pulse  out  1  one-cycle pulse on an up->down reversal
- trough_pulse  out  1  one-cycle pulse on a down->up reversal
- step_err  out  1  one-cycle pulse when |wave - previous wave| > 1
- cycle_cnt  out  CNT_W  troughs seen since reset, saturating

Behaviour:
- Reset (rst_n low, asynchronous): every output and internal register goes to 0, except dir, which resets to UP.
  - Internal registers: state=IDLE, psc=0, cnt=0, wave_d=0, hist_v=0.
  - Reset mid-frame aborts the frame; there is no drain.
- PWM FSM, two states, IDLE and RUN:
  - IDLE, en=1: next edge -> RUN; duty<=wave, cnt<=0, psc<=0, frame_start<=1.
  - IDLE, en=0: hold; cnt and psc stay 0; duty retains its last value.
  - RUN, en=0: next edge -> IDLE; cnt<=0, psc<=0. No frame completion.
  - RUN, en=1:
    - psc counts 0..PRESCALE-1 and wraps; tick = (psc==PRESCALE-1).
    - On tick, cnt<=cnt+1, wrapping 2^WIDTH-1 -> 0.
    - On tick with cnt==2^WIDTH-1: duty<=wave and frame_start<=1 on the same edge.
  - frame_start is 0 on all other edges.
- pwm_out:
  - pwm_out <= (state==RUN) && (cnt < duty), using pre-edge register values, so there is 1 clk latency behind cnt.
  - duty=0: pwm_out is never high.
  - duty=2^WIDTH-1: high for 31 of 32 ticks.
  - After en falls, pwm_out may stay high for exactly one more cycle, then goes 0.
- A wave change mid-frame has no effect until the next frame boundary.
- Monitor, runs every clk regardless of en:
  - wave_d <= wave and hist_v <= 1 on every edge.
  - When hist_v=0, no pulse or dir update occurs, e.g. the first cycle after reset.
  - With hist_v=1 and wave != wave_d, unsigned compare:
    - wave > wave_d and dir==DOWN: trough_pulse<=1, dir<=UP, cycle_cnt += 1 (saturates at all-ones).
    - wave < wave_d and dir==UP: peak_pulse<=1, dir<=DOWN.
    - Otherwise dir is unchanged.
  - step_err <= hist_v && |wave - wave_d| > 1, computed in WIDTH+1 bits, no wrap.
    - 31->0 is a step of 31 and flags an error.
  - The direction update still applies on an erroneous step.
  - wave == wave_d: no pulses, dir held.
- Simultaneous events: frame latch and monitor pulses are independent and may occur on the same edge.
- Pulses are single-cycle only; nothing is sticky.

Test Plan:
- PRESCALE=1, wave held at 8, en rises: frame_start on the first edge. Then pwm_out is high for 8 consecutive clks out of every 32, starting 1 clk after cnt=0. frame_start repeats every 32 clks.
- wave=0, then wave=31, each over full frames: pwm_out stays 0 for the whole frame; then 31 high / 1 low per frame.
- wave changes 8->20 at cnt=10 mid-frame: the current frame keeps 8 high clks, the next frame has 20; duty updates only at the boundary.
- en drops at cnt=5 with duty=8: state goes IDLE, pwm_out goes low within 2 clks, cnt=0. en re-raise gives an immediate frame_start with a fresh duty.
- Monitor, wave sequence 0,1,2,3,2,1,0,1 from reset: peak_pulse on the edge sampling the first 2 after 3; trough_pulse on the edge sampling 1 after 0; cycle_cnt=1; step_err never asserted.
- Sequence 30,31,0 gives a step_err pulse on the 0 sample. Async rst_n mid-frame forces pwm_out=0, duty=0 and cycle_cnt=0 immediately; then PRESCALE=4 run: a 32-tick frame = 128 clks.
